ex_mem_stage: RTL and testbench

- Pipeline boundary register between the execute stage (ALU result and zero flag) and the memory stage.
- Captures the ALU result plus the control and data fields that travel with it, and resolves beq/bne from the zero flag.
- Buffers up to two instructions with a valid/ready handshake on both sides, so memory-stage stalls back-pressure execute without dropping or duplicating instructions.

---
 rtl/ex_mem_stage_pkg.sv | 14 +
 rtl/pipe_skid_buffer.sv | 70 +++++++
 rtl/ex_mem_stage.sv | 57 +++++
 tb/tb_ex_mem_stage.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_stage_pkg.sv
// ex_mem_stage_pkg: shared widths, buffer state encoding and payload sizing for the EX/MEM boundary
package ex_mem_stage_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;
    // {taken, target, reg_write, mem_read, mem_write, rd, rt_data, result}
    function automatic int payload_w(input int data_w, input int reg_aw);
        return 3 * data_w + reg_aw + 4;
    endfunction
endpackage

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: two-entry valid/ready buffer with flush; main register drives the outputs, skid holds the second entry
module pipe_skid_buffer
    import ex_mem_stage_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);
    buf_state_t state, state_nxt;
    logic [WIDTH-1:0] main_q, skid_q;
    logic acc, pop, load_main, load_skid, skid_to_main;

    assign acc       = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_valid = state != EMPTY;
    assign out_data  = main_q;
    assign count     = state;

    always_comb begin
        state_nxt    = state;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    state_nxt = acc ? ONE : EMPTY;
                    load_main = acc;
                end
                ONE: begin
                    state_nxt = acc ? (pop ? ONE : FULL) : (pop ? EMPTY : ONE);
                    load_main = acc & pop;
                    load_skid = acc & ~pop;
                end
                FULL: begin
                    state_nxt    = pop ? ONE : FULL;
                    load_main    = pop;
                    skid_to_main = 1'b1;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // in_ready is registered from the next state so it never depends on out_ready combinationally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            state    <= state_nxt;
            in_ready <= state_nxt != FULL;
            if (load_main) main_q <= skid_to_main ? skid_q : in_data;
            if (load_skid) skid_q <= in_data;
        end
    end
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM boundary register resolving beq/bne and buffering two instructions with valid/ready
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              alu_zero_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic              reg_write_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              branch_i,
    input  logic              branch_ne_i,
    input  logic [DATA_W-1:0] branch_target_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              reg_write_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              branch_taken_o,
    output logic [DATA_W-1:0] branch_target_o,
    output logic [1:0]        count_o
);
    localparam int PW = payload_w(DATA_W, REG_AW);
    logic [PW-1:0] in_pl, out_pl;
    logic taken_q;

    assign in_pl = {branch_i & (alu_zero_i ^ branch_ne_i), branch_target_i,
                    reg_write_i, mem_read_i, mem_write_i, rd_addr_i, rt_data_i, alu_result_i};
    assign {taken_q, branch_target_o, reg_write_o, mem_read_o, mem_write_o,
            rd_addr_o, rt_data_o, alu_result_o} = out_pl;
    assign branch_taken_o = out_valid_o & taken_q;

    pipe_skid_buffer #(.WIDTH(PW)) u_buf (
        .clk       (clk_i),
        .rst_n     (rst_i),
        .flush     (flush_i),
        .in_valid  (in_valid_i),
        .in_ready  (in_ready_o),
        .in_data   (in_pl),
        .out_valid (out_valid_o),
        .out_ready (out_ready_i),
        .out_data  (out_pl),
        .count     (count_o)
    );
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed and randomized checks of ex_mem_stage against a queue-based reference model
module tb_ex_mem_stage;
    logic        clk_i, rst_i, flush_i, in_valid_i, in_ready_o;
    logic [31:0] alu_result_i, rt_data_i, branch_target_i;
    logic        alu_zero_i, reg_write_i, mem_read_i, mem_write_i, branch_i, branch_ne_i;
    logic [4:0]  rd_addr_i;
    logic        out_valid_o, out_ready_i;
    logic [31:0] alu_result_o, rt_data_o, branch_target_o;
    logic [4:0]  rd_addr_o;
    logic        reg_write_o, mem_read_o, mem_write_o, branch_taken_o;
    logic [1:0]  count_o;

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] rt;
        logic [4:0]  rd;
        logic        rw, mr, mw, taken;
        logic [31:0] tgt;
    } ent_t;
    ent_t q[$];

    ex_mem_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i), .rt_data_i(rt_data_i),
        .rd_addr_i(rd_addr_i), .reg_write_i(reg_write_i), .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i), .branch_i(branch_i), .branch_ne_i(branch_ne_i),
        .branch_target_i(branch_target_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .alu_result_o(alu_result_o), .rt_data_o(rt_data_o), .rd_addr_o(rd_addr_o),
        .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .branch_taken_o(branch_taken_o), .branch_target_o(branch_target_o), .count_o(count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic ent_t cur_in();
        ent_t e;
        e.res   = alu_result_i;
        e.rt    = rt_data_i;
        e.rd    = rd_addr_i;
        e.rw    = reg_write_i;
        e.mr    = mem_read_i;
        e.mw    = mem_write_i;
        e.taken = branch_i && (alu_zero_i != branch_ne_i);
        e.tgt   = branch_target_i;
        return e;
    endfunction

    // Reference: a FIFO of at most two entries; pop on a presented handshake, push when not full
    always @(posedge clk_i) begin
        if (!rst_i || flush_i) q.delete();
        else if (in_valid_i && q.size() < 2) begin
            if (q.size() > 0 && out_ready_i) void'(q.pop_front());
            q.push_back(cur_in());
        end else if (q.size() > 0 && out_ready_i) void'(q.pop_front());
    end

    task automatic rand_payload();
        alu_result_i    = $urandom;
        rt_data_i       = $urandom;
        rd_addr_i       = 5'($urandom);
        reg_write_i     = 1'($urandom_range(0, 1));
        mem_read_i      = 1'($urandom_range(0, 1));
        mem_write_i     = 1'($urandom_range(0, 1));
        branch_i        = 1'($urandom_range(0, 1));
        branch_ne_i     = 1'($urandom_range(0, 1));
        alu_zero_i      = 1'($urandom_range(0, 1));
        branch_target_i = $urandom;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b0; flush_i = 1'b0;
        rand_payload();
        repeat (3) @(negedge clk_i);
        n_tot++; if (out_valid_o !== 1'b0) $display("FAIL reset out_valid: got %b want 0", out_valid_o); else n_pass++;
        n_tot++; if (count_o !== 2'd0) $display("FAIL reset count: got %0d want 0", count_o); else n_pass++;
        n_tot++;
        if ({alu_result_o, rt_data_o, rd_addr_o, reg_write_o, mem_read_o, mem_write_o, branch_taken_o, branch_target_o} !== '0)
            $display("FAIL reset payload: got %h %h %h %b%b%b%b %h want all 0", alu_result_o, rt_data_o, rd_addr_o,
                     reg_write_o, mem_read_o, mem_write_o, branch_taken_o, branch_target_o);
        else n_pass++;
        rst_i = 1'b1; in_valid_i = 1'b0;
        @(negedge clk_i);
        n_tot++; if (in_ready_o !== 1'b1) $display("FAIL reset in_ready: got %b want 1", in_ready_o); else n_pass++;
    endtask

    task automatic test_single();
        rand_payload();
        in_valid_i = 1'b1; out_ready_i = 1'b1; alu_result_i = 32'h5; rd_addr_i = 5'd8; reg_write_i = 1'b1; branch_i = 1'b0;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        n_tot++; if (out_valid_o !== 1'b1) $display("FAIL single valid: got %b want 1", out_valid_o); else n_pass++;
        n_tot++; if (alu_result_o !== 32'h5) $display("FAIL single result: got %h want 5", alu_result_o); else n_pass++;
        n_tot++; if (rd_addr_o !== 5'd8 || reg_write_o !== 1'b1) $display("FAIL single rd/rw: got %0d/%b want 8/1", rd_addr_o, reg_write_o); else n_pass++;
        @(negedge clk_i);
        n_tot++; if (out_valid_o !== 1'b0) $display("FAIL single drain: got %b want 0", out_valid_o); else n_pass++;
    endtask

    task automatic test_branch();
        logic ne_t[3]  = '{1'b0, 1'b1, 1'b1};
        logic z_t[3]   = '{1'b1, 1'b1, 1'b0};
        logic exp_t[3] = '{1'b1, 1'b0, 1'b1};
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_payload();
            in_valid_i = 1'b1; branch_i = 1'b1; branch_ne_i = ne_t[i]; alu_zero_i = z_t[i]; branch_target_i = 32'h40;
            @(negedge clk_i);
            in_valid_i = 1'b0;
            n_tot++; if (branch_taken_o !== exp_t[i]) $display("FAIL branch %0d taken: got %b want %b", i, branch_taken_o, exp_t[i]); else n_pass++;
            n_tot++; if (branch_target_o !== 32'h40) $display("FAIL branch %0d target: got %h want 40", i, branch_target_o); else n_pass++;
            @(negedge clk_i);
        end
    endtask

    task automatic test_backpressure();
        rand_payload();
        out_ready_i = 1'b0; in_valid_i = 1'b1; alu_result_i = 32'd1;
        @(negedge clk_i);
        alu_result_i = 32'd2;
        @(negedge clk_i);
        alu_result_i = 32'd3;
        n_tot++; if (in_ready_o !== 1'b0) $display("FAIL bp in_ready after B: got %b want 0", in_ready_o); else n_pass++;
        @(negedge clk_i);
        n_tot++; if (count_o !== 2'd2) $display("FAIL bp count: got %0d want 2", count_o); else n_pass++;
        n_tot++; if (alu_result_o !== 32'd1) $display("FAIL bp stall hold: got %0d want 1", alu_result_o); else n_pass++;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        n_tot++; if (alu_result_o !== 32'd2 || out_valid_o !== 1'b1) $display("FAIL bp second: got %0d/%b want 2/1", alu_result_o, out_valid_o); else n_pass++;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        n_tot++; if (alu_result_o !== 32'd3 || count_o !== 2'd1) $display("FAIL bp third: got %0d/%0d want 3/1", alu_result_o, count_o); else n_pass++;
        @(negedge clk_i);
        n_tot++; if (out_valid_o !== 1'b0) $display("FAIL bp drain: got %b want 0", out_valid_o); else n_pass++;
    endtask

    task automatic test_flush();
        rand_payload();
        out_ready_i = 1'b0; in_valid_i = 1'b1; branch_i = 1'b1; alu_zero_i = 1'b1; branch_ne_i = 1'b0;
        repeat (2) @(negedge clk_i);
        flush_i = 1'b1; alu_result_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        flush_i = 1'b0; in_valid_i = 1'b0;
        n_tot++; if (out_valid_o !== 1'b0) $display("FAIL flush valid: got %b want 0", out_valid_o); else n_pass++;
        n_tot++; if (count_o !== 2'd0) $display("FAIL flush count: got %0d want 0", count_o); else n_pass++;
        n_tot++; if (in_ready_o !== 1'b1) $display("FAIL flush in_ready: got %b want 1", in_ready_o); else n_pass++;
        n_tot++; if (branch_taken_o !== 1'b0) $display("FAIL flush taken: got %b want 0", branch_taken_o); else n_pass++;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        n_tot++; if (out_valid_o !== 1'b0) $display("FAIL flush leak: got %b want 0", out_valid_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        out_ready_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rand_payload();
            in_valid_i = i < 8;
            alu_result_i = 32'(100 + i);
            @(negedge clk_i);
            n_tot++;
            if (out_valid_o !== 1'b1 || alu_result_o !== 32'(100 + i) || count_o !== 2'd1)
                $display("FAIL stream %0d: got v=%b r=%0d c=%0d want v=1 r=%0d c=1", i, out_valid_o, alu_result_o, count_o, 100 + i);
            else n_pass++;
            if (i == 7) in_valid_i = 1'b0;
            if (i == 7) break;
        end
        @(negedge clk_i);
        n_tot++; if (out_valid_o !== 1'b0) $display("FAIL stream drain: got %b want 0", out_valid_o); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_payload();
            in_valid_i  = 1'($urandom_range(0, 3) != 0);
            out_ready_i = 1'($urandom_range(0, 2) != 0);
            flush_i     = 1'($urandom_range(0, 29) == 0);
            rst_i       = $urandom_range(0, 59) != 0;
            @(negedge clk_i);
            n_tot++; if (out_valid_o !== (q.size() != 0)) $display("FAIL rand %0d valid: got %b want %b", i, out_valid_o, q.size() != 0); else n_pass++;
            n_tot++; if (count_o !== 2'(q.size())) $display("FAIL rand %0d count: got %0d want %0d", i, count_o, q.size()); else n_pass++;
            n_tot++; if (in_ready_o !== (q.size() < 2)) $display("FAIL rand %0d in_ready: got %b want %b", i, in_ready_o, q.size() < 2); else n_pass++;
            n_tot++;
            if (q.size() == 0 ? branch_taken_o !== 1'b0
                : {alu_result_o, rt_data_o, rd_addr_o, reg_write_o, mem_read_o, mem_write_o, branch_taken_o, branch_target_o} !== q[0])
                $display("FAIL rand %0d payload: got %h %h %h %b%b%b%b %h", i, alu_result_o, rt_data_o, rd_addr_o,
                         reg_write_o, mem_read_o, mem_write_o, branch_taken_o, branch_target_o);
            else n_pass++;
        end
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        rand_payload();
        test_reset();
        test_single();
        test_branch();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
